// File: rtl/subtractor_64bit_seq.sv
// Multi-cycle 64-bit subtractor: Diff = A - B - Bin, one CHUNK-bit slice per clock,
// least-significant slice first, with the borrow carried in a register between slices.
module subtractor_64bit_seq #(
  parameter int CHUNK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Bin,
  output logic        busy,
  output logic        done,
  output logic [63:0] Diff,
  output logic        Bout,
  output logic        V
);

  localparam int DATA_W = 64;
  localparam int NSLICE = DATA_W / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                brw;
  logic [DATA_W-1:0]   a_l;
  logic [DATA_W-1:0]   b_l;
  logic [CHUNK-1:0]    a_sl;
  logic [CHUNK-1:0]    b_sl;
  logic [CHUNK:0]      sl_res;
  logic                last;

  // Top bit of the (CHUNK+1)-bit difference is the slice borrow-out.
  function automatic logic [CHUNK:0] sub_slice(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             bi);
    return {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bi};
  endfunction

  assign a_sl   = a_l[cnt*CHUNK +: CHUNK];
  assign b_sl   = b_l[cnt*CHUNK +: CHUNK];
  assign sl_res = sub_slice(a_sl, b_sl, brw);
  assign last   = (cnt == CW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_l   <= A;
            b_l   <= B;
            brw   <= Bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          Diff[cnt*CHUNK +: CHUNK] <= sl_res[CHUNK-1:0];
          brw <= sl_res[CHUNK];
          cnt <= cnt + 1'b1;
          // The last slice holds bit 63, so its MSB is the final sign of Diff.
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Bout  <= sl_res[CHUNK];
            V     <= (a_l[DATA_W-1] ^ b_l[DATA_W-1]) & (sl_res[CHUNK-1] ^ a_l[DATA_W-1]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_64bit_seq.sv
// Scoreboard bench: four instances (CHUNK = 16, 1, 8, 64) share operands; expected
// results are queued at issue time and popped by per-instance monitors on done.
module tb_subtractor_64bit_seq;

  typedef struct {
    logic [63:0] d;
    logic        bo;
    logic        v;
    int          iss;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start = '0;
  logic [63:0] A_i = '0;
  logic [63:0] B_i = '0;
  logic        Bin_i = 1'b0;
  logic [3:0]  busy, done, bout, v;
  logic [63:0] diff [4];

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CHK = (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 8 : 64;
    localparam int NS  = 64 / CHK;

    subtractor_64bit_seq #(.CHUNK(CHK)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start[g]),
      .A    (A_i),
      .B    (B_i),
      .Bin  (Bin_i),
      .busy (busy[g]),
      .done (done[g]),
      .Diff (diff[g]),
      .Bout (bout[g]),
      .V    (v[g])
    );

    exp_t e;
    logic pd   = 1'b0;
    int   bcnt = 0;

    always @(negedge clk) begin
      if (done[g] === 1'b1) begin
        chk($sformatf("single_pulse_c%0d", CHK), 64'(pd), 64'd0);
        if (q[g].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done_c%0d: got done with Diff=%h required no done", CHK, diff[g]);
        end else begin
          e = q[g].pop_front();
          chk($sformatf("diff_c%0d", CHK), diff[g], e.d);
          chk($sformatf("bout_c%0d", CHK), 64'(bout[g]), 64'(e.bo));
          chk($sformatf("v_c%0d", CHK), 64'(v[g]), 64'(e.v));
          chk($sformatf("latency_c%0d", CHK), 64'(cyc - e.iss), 64'(NS + 1));
          chk($sformatf("busy_len_c%0d", CHK), 64'(bcnt), 64'(NS));
        end
        bcnt = 0;
      end else if (busy[g] === 1'b1) begin
        bcnt++;
      end else begin
        bcnt = 0;
      end
      pd = done[g];
    end
  end

  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic bi);
    logic [64:0] r;
    logic        ov;
    r  = {1'b0, a} - {1'b0, b} - {64'd0, bi};
    ov = (a[63] != b[63]) && (r[63] != a[63]);
    return {ov, r};
  endfunction

  task automatic issue(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b,
                       input logic bi, input logic [63:0] ed, input logic ebo, input logic ev);
    A_i   = a;
    B_i   = b;
    Bin_i = bi;
    for (int j = 0; j < 4; j++) begin
      if (m[j]) begin
        start[j] = 1'b1;
        q[j].push_back('{d: ed, bo: ebo, v: ev, iss: cyc});
      end
    end
    @(negedge clk);
    start = '0;
  endtask

  task automatic wait_idle(input logic [3:0] m);
    int n;
    n = 0;
    while (((busy & m) != 4'd0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 64'(n >= 300), 64'd0);
  endtask

  task automatic run(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b,
                     input logic bi, input logic [63:0] ed, input logic ebo, input logic ev);
    issue(m, a, b, bi, ed, ebo, ev);
    wait_idle(m);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [65:0] r;
    logic [63:0] ra, rb;
    logic        rbi;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rst_busy_%0d", j), 64'(busy[j]), 64'd0);
      chk($sformatf("rst_done_%0d", j), 64'(done[j]), 64'd0);
      chk($sformatf("rst_diff_%0d", j), diff[j], 64'd0);
      chk($sformatf("rst_bout_v_%0d", j), 64'({bout[j], v[j]}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors on every slice width
    run(4'b1111, 64'd123, 64'd123, 1'b0, 64'd0, 1'b0, 1'b0);
    run(4'b1111, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run(4'b1111, 64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0);
    run(4'b1111, 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    run(4'b1111, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run(4'b1111, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
        64'h8000_0000_0000_0000, 1'b1, 1'b1);
    run(4'b1111, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted
    issue(4'b0001, 64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 1'b0);
    @(negedge clk);
    A_i = 64'd99;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(4'b0001);
    run(4'b0001, 64'd99, 64'd9, 1'b0, 64'd90, 1'b0, 1'b0);

    // Reset mid-operation abandons the result
    issue(4'b0001, 64'd50, 64'd20, 1'b0, 64'd30, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q[0].delete();
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_done", 64'(done[0]), 64'd0);
    chk("midrst_diff", diff[0], 64'd0);
    repeat (10) @(negedge clk);
    run(4'b0001, 64'd1000, 64'd1, 1'b1, 64'd998, 1'b0, 1'b0);

    // Random vectors against the 65-bit reference
    for (int i = 0; i < 1000; i++) begin
      ra  = {$urandom, $urandom};
      rb  = (i % 7 == 0) ? ra : {$urandom, $urandom};
      rbi = 1'($urandom_range(0, 1));
      r   = model(ra, rb, rbi);
      run((i < 30) ? 4'b1111 : 4'b1101, ra, rb, rbi, r[63:0], r[64], r[65]);
    end

    repeat (3) @(negedge clk);
    for (int j = 0; j < 4; j++)
      chk($sformatf("queue_empty_%0d", j), 64'(q[j].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
